morse_key_ctrl: RTL and testbench

Straight-key front-end controller for the Morse translator path. It converts a single raw key level into the one-cycle `dot_inp` / `dash_inp` / `char_space_inp` / `word_space_inp` strobes that `trans_fsm` consumes. It does this by timing mark and gap durations against a programmable unit length. It sits in front of `trans_fsm` inside the top level and is the only block that sequences that translator's inputs.

---
 rtl/morse_key_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_morse_key_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/morse_key_ctrl.sv
// rtl/morse_key_ctrl.sv - straight-key mark/gap timer producing Morse element strobes
//
// Purpose: times key-down (mark) and key-up (gap) durations against a
// programmable unit length and emits one-cycle strobes for the translator:
// dot, dash, character space, word space, plus an over-long-press error.
//
// Optional feature macro: MORSE_KEY_DEBOUNCE_EN
//   defined   - key_in passes through a 2-flop synchronizer and a
//               DEBOUNCE_CYCLES debounce filter before timing
//   undefined - key_in is used directly (must be synchronous, glitch-free)
//
// Ports:
//   clk            in  single clock, rising edge
//   rst            in  asynchronous active-low reset
//   key_in         in  raw key level, 1 = pressed
//   enable         in  1 = keying accepted, 0 = abort to idle
//   dot_out        out one-cycle dot strobe
//   dash_out       out one-cycle dash strobe
//   char_space_out out one-cycle character-space strobe
//   word_space_out out one-cycle word-space strobe
//   err_out        out one-cycle over-long-press strobe
//   busy           out high whenever the controller is not idle

module morse_key_ctrl #(
    parameter int UNIT_CYCLES     = 4,
    parameter int CNT_W           = 8,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    input  logic enable,
    output logic dot_out,
    output logic dash_out,
    output logic char_space_out,
    output logic word_space_out,
    output logic err_out,
    output logic busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MARK = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_WGAP = 3'd3;
    localparam logic [2:0] S_LOCK = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DASH_MIN  = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_GAP  = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP  = CNT_W'(5 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] ERR_LEN   = CNT_W'(8 * UNIT_CYCLES);

    // Reject parameter sets where the error threshold would not fit the counter.
    if (UNIT_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || (8 * UNIT_CYCLES) >= (2 ** CNT_W)) begin : g_param_check
        $error("morse_key_ctrl: illegal parameter combination");
    end

    logic key_c;

`ifdef MORSE_KEY_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync_1;
    logic            sync_2;
    logic            key_db;
    logic [DB_W-1:0] db_cnt;

    // key_db follows sync_2 only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            key_db <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync_1 <= key_in;
            sync_2 <= sync_1;
            if (sync_2 != key_db) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_db <= sync_2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign key_c = key_db;
`else
    assign key_c = key_in;
`endif

    logic [2:0]       state;
    logic [2:0]       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             dot_n;
    logic             dash_n;
    logic             cs_n;
    logic             ws_n;
    logic             err_n;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;

    // Thresholds compare the incremented count so the strobe lands in the
    // cycle right after the deciding sample.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dot_n   = 1'b0;
        dash_n  = 1'b0;
        cs_n    = 1'b0;
        ws_n    = 1'b0;
        err_n   = 1'b0;
        if (!enable) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_c) begin
                        state_n = S_MARK;
                        cnt_n   = CNT_ONE;
                    end
                end
                S_MARK: begin
                    if (key_c) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == ERR_LEN) begin
                            err_n   = 1'b1;
                            state_n = S_LOCK;
                        end
                    end else begin
                        if (cnt < DASH_MIN) begin
                            dot_n = 1'b1;
                        end else begin
                            dash_n = 1'b1;
                        end
                        state_n = S_GAP;
                        cnt_n   = CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (key_c) begin
                        state_n = S_MARK;
                        cnt_n   = CNT_ONE;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CHAR_GAP) begin
                            cs_n    = 1'b1;
                            state_n = S_WGAP;
                        end
                    end
                end
                S_WGAP: begin
                    if (key_c) begin
                        state_n = S_MARK;
                        cnt_n   = CNT_ONE;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == WORD_GAP) begin
                            ws_n    = 1'b1;
                            state_n = S_IDLE;
                            cnt_n   = '0;
                        end
                    end
                end
                S_LOCK: begin
                    // Release reopens the gap so the partial character still
                    // gets closed by a character space.
                    if (!key_c) begin
                        state_n = S_GAP;
                        cnt_n   = CNT_ONE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            dot_out        <= 1'b0;
            dash_out       <= 1'b0;
            char_space_out <= 1'b0;
            word_space_out <= 1'b0;
            err_out        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            dot_out        <= dot_n;
            dash_out       <= dash_n;
            char_space_out <= cs_n;
            word_space_out <= ws_n;
            err_out        <= err_n;
            busy           <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_morse_key_ctrl.sv
// tb/tb_morse_key_ctrl.sv - scoreboard bench for morse_key_ctrl

module tb_morse_key_ctrl;

    localparam int U = 4;
`ifdef MORSE_KEY_DEBOUNCE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 0;
`endif

    localparam logic [4:0] EV_DOT  = 5'b10000;
    localparam logic [4:0] EV_DASH = 5'b01000;
    localparam logic [4:0] EV_CS   = 5'b00100;
    localparam logic [4:0] EV_WS   = 5'b00010;
    localparam logic [4:0] EV_ERR  = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_in = 1'b0;
    logic enable = 1'b1;
    logic dot_out, dash_out, char_space_out, word_space_out, err_out, busy;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         t;
        logic [4:0] code;
    } ev_t;
    ev_t sb[$];

    morse_key_ctrl #(
        .UNIT_CYCLES(U),
        .CNT_W(8),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .enable(enable),
        .dot_out(dot_out),
        .dash_out(dash_out),
        .char_space_out(char_space_out),
        .word_space_out(word_space_out),
        .err_out(err_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Expected strobe at the cycle following sample edge t.
    task automatic expect_ev(input int t, input logic [4:0] code);
        sb.push_back('{t + LAT, code});
    endtask

    // Hold key at v for n sampling edges; called and returns at a negedge.
    task automatic drive(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
    endtask

    logic [4:0] obs;
    always @(negedge clk) begin
        if (rst) begin
            obs = {dot_out, dash_out, char_space_out, word_space_out, err_out};
            while (sb.size() > 0 && sb[0].t < cyc) begin
                check("missed_strobe", 32'd0, {27'd0, sb[0].code});
                void'(sb.pop_front());
            end
            if (obs != 5'd0) begin
                if (sb.size() == 0 || sb[0].t != cyc) begin
                    check("spurious_strobe", {27'd0, obs}, 32'd0);
                end else begin
                    check("strobe_code", {27'd0, obs}, {27'd0, sb[0].code});
                    void'(sb.pop_front());
                end
            end
            if (word_space_out) check("busy_at_word_space", {31'd0, busy}, 32'd0);
        end
    end

    int e;
    int g;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_strobes", {27'd0, dot_out, dash_out, char_space_out, word_space_out, err_out}, 32'd0);
        rst = 1'b1;
        drive(1'b0, 50);
        check("idle_busy_50", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a mark.
        drive(1'b1, 3 + LAT);
        #2 rst = 1'b0;
        #1;
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_strobes", {27'd0, dot_out, dash_out, char_space_out, word_space_out, err_out}, 32'd0);
        key_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 20);

        // Dot followed by full word gap.
        e = cyc + 1;
        expect_ev(e + 3, EV_DOT);
        expect_ev(e + 3 + 7, EV_CS);
        expect_ev(e + 3 + 19, EV_WS);
        drive(1'b1, 3);
        drive(1'b0, 10);
        check("busy_in_gap", {31'd0, busy}, 32'd1);
        drive(1'b0, 20);

        // Dot/dash boundary.
        e = cyc + 1;
        expect_ev(e + 7, EV_DOT);
        expect_ev(e + 14, EV_CS);
        expect_ev(e + 26, EV_WS);
        drive(1'b1, 7);
        drive(1'b0, 25);
        e = cyc + 1;
        expect_ev(e + 8, EV_DASH);
        expect_ev(e + 15, EV_CS);
        expect_ev(e + 27, EV_WS);
        drive(1'b1, 8);
        drive(1'b0, 25);

        // Gap boundary: 7-cycle gap suppresses char space; press at gap 10 suppresses word space.
        e = cyc + 1;
        expect_ev(e + 3, EV_DOT);
        drive(1'b1, 3);
        drive(1'b0, 7);
        e = cyc + 1;
        expect_ev(e + 3, EV_DOT);
        drive(1'b1, 3);
        g = cyc + 1;
        expect_ev(g + 7, EV_CS);
        drive(1'b0, 9);
        e = cyc + 1;
        expect_ev(e + 3, EV_DOT);
        expect_ev(e + 3 + 7, EV_CS);
        expect_ev(e + 3 + 19, EV_WS);
        drive(1'b1, 3);
        drive(1'b0, 25);

        // Over-long press.
        e = cyc + 1;
        expect_ev(e + 31, EV_ERR);
        expect_ev(e + 40 + 7, EV_CS);
        expect_ev(e + 40 + 19, EV_WS);
        drive(1'b1, 40);
        drive(1'b0, 25);

        // Abort: enable drops exactly when the key releases; the dot is discarded.
        drive(1'b1, 3 + LAT);
        key_in = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        drive(1'b0, 30);
        enable = 1'b1;
        drive(1'b0, 10);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);

`ifdef MORSE_KEY_DEBOUNCE_EN
        drive(1'b1, 2);
        drive(1'b0, 40);
        check("glitch_busy", {31'd0, busy}, 32'd0);
`endif

        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
